// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: decodes the D-stage opcode into a control word and
// carries it through the E, M and W pipeline registers. Handles stall/flush
// from the hazard unit and tracks accepted illegal opcodes.
module ctrl_pipe_decoder #(
    parameter int ALUOPW  = 3,
    parameter int EXT_OPS = 1,
    parameter int CNTW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op_d,
    input  logic              valid_d,
    input  logic              stall_e,
    input  logic              flush_e,
    output logic              jump_d,
    output logic              illegal_d,
    output logic              valid_e,
    output logic              regwrite_e,
    output logic              regdst_e,
    output logic              alusrc_e,
    output logic              branch_e,
    output logic              bne_e,
    output logic              memwrite_e,
    output logic              memtoreg_e,
    output logic              zeroext_e,
    output logic              link_e,
    output logic [ALUOPW-1:0] aluop_e,
    output logic              valid_m,
    output logic              regwrite_m,
    output logic              memwrite_m,
    output logic              memtoreg_m,
    output logic              link_m,
    output logic              valid_w,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic              link_w,
    output logic              illegal_sticky,
    output logic [CNTW-1:0]   illegal_cnt
);

    generate
        if (ALUOPW < 3) begin : g_bad_aluopw
            $error("ctrl_pipe_decoder: ALUOPW must be >= 3");
        end
    endgenerate

    localparam bit EXT = (EXT_OPS != 0);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FN  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Decoded D-stage control word
    logic              rw_d, rd_d, as_d, br_d, bne_d, mw_d, m2r_d, ze_d, lk_d, jmp_d, legal_d;
    logic [ALUOPW-1:0] aluop_d;

    // Opcode decode; unknown opcodes yield an all-zero word and legal_d=0
    always_comb begin
        rw_d = 1'b0; rd_d = 1'b0; as_d = 1'b0; br_d = 1'b0; bne_d = 1'b0;
        mw_d = 1'b0; m2r_d = 1'b0; ze_d = 1'b0; lk_d = 1'b0; jmp_d = 1'b0;
        aluop_d = '0;
        legal_d = 1'b1;
        case (op_d)
            6'b000000: begin rw_d = 1'b1; rd_d = 1'b1; aluop_d[2:0] = ALU_FN; end
            6'b100011: begin rw_d = 1'b1; as_d = 1'b1; m2r_d = 1'b1; aluop_d[2:0] = ALU_ADD; end
            6'b101011: begin as_d = 1'b1; mw_d = 1'b1; aluop_d[2:0] = ALU_ADD; end
            6'b000100: begin br_d = 1'b1; aluop_d[2:0] = ALU_SUB; end
            6'b001000: begin rw_d = 1'b1; as_d = 1'b1; aluop_d[2:0] = ALU_ADD; end
            6'b000010: begin jmp_d = 1'b1; end
            6'b000101: begin
                if (EXT) begin br_d = 1'b1; bne_d = 1'b1; aluop_d[2:0] = ALU_SUB; end
                else legal_d = 1'b0;
            end
            6'b001100: begin
                if (EXT) begin rw_d = 1'b1; as_d = 1'b1; ze_d = 1'b1; aluop_d[2:0] = ALU_AND; end
                else legal_d = 1'b0;
            end
            6'b001101: begin
                if (EXT) begin rw_d = 1'b1; as_d = 1'b1; ze_d = 1'b1; aluop_d[2:0] = ALU_OR; end
                else legal_d = 1'b0;
            end
            6'b001010: begin
                if (EXT) begin rw_d = 1'b1; as_d = 1'b1; aluop_d[2:0] = ALU_SLT; end
                else legal_d = 1'b0;
            end
            6'b000011: begin
                if (EXT) begin rw_d = 1'b1; lk_d = 1'b1; jmp_d = 1'b1; end
                else legal_d = 1'b0;
            end
            default: legal_d = 1'b0;
        endcase
    end

    assign jump_d    = valid_d & jmp_d;
    assign illegal_d = valid_d & ~legal_d;

    // An illegal opcode enters E as a bubble, so valid also drops
    logic vld_in;
    assign vld_in = valid_d & legal_d;

    logic              valid_e_q, rw_e_q, rd_e_q, as_e_q, br_e_q, bne_e_q, mw_e_q, m2r_e_q, ze_e_q, lk_e_q;
    logic [ALUOPW-1:0] aluop_e_q;

    // E register: flush beats stall, stall holds, otherwise load from D
    always_ff @(posedge clk) begin
        if (!reset || flush_e || (!stall_e && !valid_d)) begin
            valid_e_q <= 1'b0; rw_e_q <= 1'b0; rd_e_q <= 1'b0; as_e_q <= 1'b0;
            br_e_q <= 1'b0; bne_e_q <= 1'b0; mw_e_q <= 1'b0; m2r_e_q <= 1'b0;
            ze_e_q <= 1'b0; lk_e_q <= 1'b0; aluop_e_q <= '0;
        end else if (!stall_e) begin
            valid_e_q <= vld_in; rw_e_q <= rw_d; rd_e_q <= rd_d; as_e_q <= as_d;
            br_e_q <= br_d; bne_e_q <= bne_d; mw_e_q <= mw_d; m2r_e_q <= m2r_d;
            ze_e_q <= ze_d; lk_e_q <= lk_d; aluop_e_q <= aluop_d;
        end
    end

    logic valid_m_q, rw_m_q, mw_m_q, m2r_m_q, lk_m_q;

    // M register: bubble while E is held; stall+flush still advances E into M
    always_ff @(posedge clk) begin
        if (!reset || (stall_e && !flush_e)) begin
            valid_m_q <= 1'b0; rw_m_q <= 1'b0; mw_m_q <= 1'b0; m2r_m_q <= 1'b0; lk_m_q <= 1'b0;
        end else begin
            valid_m_q <= valid_e_q; rw_m_q <= rw_e_q; mw_m_q <= mw_e_q;
            m2r_m_q <= m2r_e_q; lk_m_q <= lk_e_q;
        end
    end

    logic valid_w_q, rw_w_q, m2r_w_q, lk_w_q;

    // W register: always follows M
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_w_q <= 1'b0; rw_w_q <= 1'b0; m2r_w_q <= 1'b0; lk_w_q <= 1'b0;
        end else begin
            valid_w_q <= valid_m_q; rw_w_q <= rw_m_q; m2r_w_q <= m2r_m_q; lk_w_q <= lk_m_q;
        end
    end

    // Illegal accounting counts only accepted instructions, so a stalled op
    // is counted once on the cycle it finally moves and a flushed one never
    logic            accept, count_en;
    logic            sticky_q, sticky_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign accept   = valid_d & ~stall_e & ~flush_e;
    assign count_en = accept & ~legal_d;

    // Next-state for sticky flag and saturating counter
    always_comb begin
        sticky_d = sticky_q | count_en;
        cnt_d    = cnt_q;
        if (count_en && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + CNTW'(1);
    end

    // Illegal-op state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_e    = valid_e_q;
    assign regwrite_e = rw_e_q;
    assign regdst_e   = rd_e_q;
    assign alusrc_e   = as_e_q;
    assign branch_e   = br_e_q;
    assign bne_e      = bne_e_q;
    assign memwrite_e = mw_e_q;
    assign memtoreg_e = m2r_e_q;
    assign zeroext_e  = ze_e_q;
    assign link_e     = lk_e_q;
    assign aluop_e    = aluop_e_q;
    assign valid_m    = valid_m_q;
    assign regwrite_m = rw_m_q;
    assign memwrite_m = mw_m_q;
    assign memtoreg_m = m2r_m_q;
    assign link_m     = lk_m_q;
    assign valid_w    = valid_w_q;
    assign regwrite_w = rw_w_q;
    assign memtoreg_w = m2r_w_q;
    assign link_w     = lk_w_q;
    assign illegal_sticky = sticky_q;
    assign illegal_cnt    = cnt_q;

endmodule
